// File: rtl/pet_button_conditioner.sv
// Button input stage: synchronizes, debounces and classifies three raw push-buttons
// into press / short / long strobes plus a debounced held level per button.
`timescale 1ns/1ps

module pet_button_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES   = 1_000_000,
    parameter int unsigned LONG_PRESS_CYCLES = 150_000_000,
    parameter bit          ACTIVE_LOW        = 1'b1
) (
    input  logic       clock,
    input  logic       Reset,
    input  logic [2:0] btn_raw,
    output logic [2:0] held,
    output logic [2:0] press_pulse,
    output logic [2:0] short_pulse,
    output logic [2:0] long_pulse
);

    localparam int unsigned NUM_BTN = 3;
    localparam int unsigned CW      = $clog2(LONG_PRESS_CYCLES + 1);
    localparam int unsigned RW      = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [CW-1:0] CNT_DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_LONG_LAST = CW'(LONG_PRESS_CYCLES - 1);
    localparam logic [RW-1:0] RCNT_LAST     = RW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DB_PRESS,
        S_PRESSED,
        S_LONG,
        S_DB_RELEASE
    } state_t;

    logic [NUM_BTN-1:0] sync1;
    logic [NUM_BTN-1:0] sync2;
    logic [NUM_BTN-1:0] p;

    // Two-flop synchronizer; resets to the released pin level
    always_ff @(posedge clock or posedge Reset) begin
        if (Reset) begin
            sync1 <= {NUM_BTN{ACTIVE_LOW}};
            sync2 <= {NUM_BTN{ACTIVE_LOW}};
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    assign p = sync2 ^ {NUM_BTN{ACTIVE_LOW}};

    for (genvar ch = 0; ch < NUM_BTN; ch++) begin : g_ch
        state_t        state;
        logic [CW-1:0] cnt;
        logic [RW-1:0] rcnt;
        logic          long_flag;
        logic          held_q;
        logic          press_q;
        logic          short_q;
        logic          long_q;

        // Hold time keeps accumulating through release bounce, saturating at the long threshold
        always_ff @(posedge clock or posedge Reset) begin
            if (Reset) begin
                state     <= S_IDLE;
                cnt       <= '0;
                rcnt      <= '0;
                long_flag <= 1'b0;
                held_q    <= 1'b0;
                press_q   <= 1'b0;
                short_q   <= 1'b0;
                long_q    <= 1'b0;
            end else begin
                press_q <= 1'b0;
                short_q <= 1'b0;
                long_q  <= 1'b0;
                case (state)
                    S_IDLE: begin
                        if (p[ch]) begin
                            state <= S_DB_PRESS;
                            cnt   <= '0;
                        end
                    end
                    S_DB_PRESS: begin
                        if (!p[ch]) begin
                            state <= S_IDLE;
                        end else if (cnt == CNT_DB_LAST) begin
                            state     <= S_PRESSED;
                            cnt       <= '0;
                            long_flag <= 1'b0;
                            press_q   <= 1'b1;
                            held_q    <= 1'b1;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    S_PRESSED: begin
                        if (!p[ch]) begin
                            state <= S_DB_RELEASE;
                            rcnt  <= '0;
                            if (cnt != CNT_LONG_LAST) cnt <= cnt + CW'(1);
                        end else if (cnt == CNT_LONG_LAST) begin
                            state     <= S_LONG;
                            long_q    <= 1'b1;
                            long_flag <= 1'b1;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    S_LONG: begin
                        if (!p[ch]) begin
                            state <= S_DB_RELEASE;
                            rcnt  <= '0;
                        end
                    end
                    S_DB_RELEASE: begin
                        if (cnt != CNT_LONG_LAST) cnt <= cnt + CW'(1);
                        if (p[ch]) begin
                            state <= long_flag ? S_LONG : S_PRESSED;
                        end else if (rcnt == RCNT_LAST) begin
                            state   <= S_IDLE;
                            held_q  <= 1'b0;
                            short_q <= ~long_flag;
                        end else begin
                            rcnt <= rcnt + RW'(1);
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end

        assign held[ch]        = held_q;
        assign press_pulse[ch] = press_q;
        assign short_pulse[ch] = short_q;
        assign long_pulse[ch]  = long_q;
    end

endmodule

// File: tb/tb_pet_button_conditioner.sv
// Scoreboard bench for pet_button_conditioner: stimulus pushes expected pulse events,
// a negedge monitor pops and compares them whenever any pulse output is active.
`timescale 1ns/1ps

module tb_pet_button_conditioner;

    typedef struct {
        int         edge_no;
        logic [2:0] p;
        logic [2:0] s;
        logic [2:0] l;
    } exp_t;

    logic       clock;
    logic       Reset;
    logic [2:0] btn_raw;
    logic [2:0] held;
    logic [2:0] press_pulse;
    logic [2:0] short_pulse;
    logic [2:0] long_pulse;

    int   edge_n   = 0;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];

    pet_button_conditioner #(
        .DEBOUNCE_CYCLES  (4),
        .LONG_PRESS_CYCLES(20),
        .ACTIVE_LOW       (1'b1)
    ) dut (
        .clock      (clock),
        .Reset      (Reset),
        .btn_raw    (btn_raw),
        .held       (held),
        .press_pulse(press_pulse),
        .short_pulse(short_pulse),
        .long_pulse (long_pulse)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) edge_n <= edge_n + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h (edge %0d)", name, act, req, edge_n);
        end
    endtask

    task automatic push(input int e, input logic [2:0] p, input logic [2:0] s, input logic [2:0] l);
        exp_t x;
        x.edge_no = e;
        x.p = p;
        x.s = s;
        x.l = l;
        exp_q.push_back(x);
    endtask

    task automatic wait_until(input int e);
        while (edge_n < e) @(negedge clock);
    endtask

    // Monitor: every cycle with any pulse active must match the next expected event
    always @(negedge clock) begin
        if ((press_pulse | short_pulse | long_pulse) != 3'b000) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_pulse actual edge=%0d press=%b short=%b long=%b required none",
                         edge_n, press_pulse, short_pulse, long_pulse);
            end else begin
                exp_t x;
                x = exp_q.pop_front();
                if (x.edge_no != edge_n || x.p !== press_pulse || x.s !== short_pulse || x.l !== long_pulse) begin
                    n_fail++;
                    $display("FAIL pulse_event actual edge=%0d press=%b short=%b long=%b required edge=%0d press=%b short=%b long=%b",
                             edge_n, press_pulse, short_pulse, long_pulse, x.edge_no, x.p, x.s, x.l);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout at edge %0d", edge_n);
        $fatal(1);
    end

    initial begin
        int e0;
        int c;
        Reset   = 1'b1;
        btn_raw = 3'b111;
        repeat (3) @(negedge clock);
        check("reset_held",  32'(held),        32'h0);
        check("reset_press", 32'(press_pulse), 32'h0);
        check("reset_short", 32'(short_pulse), 32'h0);
        check("reset_long",  32'(long_pulse),  32'h0);
        Reset = 1'b0;
        repeat (5) @(negedge clock);

        // Clean short press on play
        e0 = edge_n + 1;
        push(e0 + 6,  3'b010, 3'b000, 3'b000);
        push(e0 + 18, 3'b000, 3'b010, 3'b000);
        btn_raw[1] = 1'b0;
        wait_until(e0 + 5);  check("short_held_before", 32'(held), 32'h0);
        wait_until(e0 + 6);  check("short_held_rise",   32'(held), 32'h2);
        wait_until(e0 + 11); btn_raw[1] = 1'b1;
        wait_until(e0 + 17); check("short_held_last",   32'(held), 32'h2);
        wait_until(e0 + 18); check("short_held_fall",   32'(held), 32'h0);
        repeat (8) @(negedge clock);

        // Glitches of 3 and 4 samples are rejected; 5 samples is the shortest accepted press
        e0 = edge_n + 1;
        btn_raw[2] = 1'b0;
        wait_until(e0 + 2);  btn_raw[2] = 1'b1;
        wait_until(e0 + 10); check("glitch3_held", 32'(held), 32'h0);
        e0 = edge_n + 1;
        btn_raw[2] = 1'b0;
        wait_until(e0 + 3);  btn_raw[2] = 1'b1;
        wait_until(e0 + 10); check("glitch4_held", 32'(held), 32'h0);
        e0 = edge_n + 1;
        push(e0 + 6,  3'b100, 3'b000, 3'b000);
        push(e0 + 11, 3'b000, 3'b100, 3'b000);
        btn_raw[2] = 1'b0;
        wait_until(e0 + 4);  btn_raw[2] = 1'b1;
        wait_until(e0 + 6);  check("min_press_held", 32'(held), 32'h4);
        wait_until(e0 + 16);

        // Long press on test
        e0 = edge_n + 1;
        push(e0 + 6,  3'b001, 3'b000, 3'b000);
        push(e0 + 26, 3'b000, 3'b000, 3'b001);
        btn_raw[0] = 1'b0;
        wait_until(e0 + 39); btn_raw[0] = 1'b1;
        wait_until(e0 + 45); check("long_held_last", 32'(held), 32'h1);
        wait_until(e0 + 46); check("long_held_fall", 32'(held), 32'h0);
        repeat (8) @(negedge clock);

        // Release bounce on play: press continues and still becomes long on time
        e0 = edge_n + 1;
        c  = e0 + 6;
        push(c,      3'b010, 3'b000, 3'b000);
        push(c + 20, 3'b000, 3'b000, 3'b010);
        btn_raw[1] = 1'b0;
        wait_until(c + 1); btn_raw[1] = 1'b1;
        wait_until(c + 3); btn_raw[1] = 1'b0;
        wait_until(c + 5); btn_raw[1] = 1'b1;
        wait_until(c + 7); btn_raw[1] = 1'b0;
        wait_until(c + 12); check("bounce_held", 32'(held), 32'h2);
        wait_until(c + 29); btn_raw[1] = 1'b1;
        wait_until(c + 35); check("bounce_held_last", 32'(held), 32'h2);
        wait_until(c + 36); check("bounce_held_fall", 32'(held), 32'h0);
        repeat (8) @(negedge clock);

        // Concurrent press, reset mid-hold, then re-press after reset release
        e0 = edge_n + 1;
        push(e0 + 6, 3'b111, 3'b000, 3'b000);
        btn_raw = 3'b000;
        wait_until(e0 + 8); check("conc_held", 32'(held), 32'h7);
        Reset = 1'b1;
        #1;
        check("rst_held",  32'(held),        32'h0);
        check("rst_press", 32'(press_pulse), 32'h0);
        check("rst_short", 32'(short_pulse), 32'h0);
        check("rst_long",  32'(long_pulse),  32'h0);
        repeat (3) @(negedge clock);
        Reset = 1'b0;
        e0 = edge_n + 1;
        push(e0 + 6,  3'b111, 3'b000, 3'b000);
        push(e0 + 16, 3'b000, 3'b111, 3'b000);
        wait_until(e0 + 5);  check("repress_held_before", 32'(held), 32'h0);
        wait_until(e0 + 6);  check("repress_held",        32'(held), 32'h7);
        wait_until(e0 + 9);  btn_raw = 3'b111;
        wait_until(e0 + 16); check("repress_held_fall",   32'(held), 32'h0);
        wait_until(e0 + 40);

        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pet_button_conditioner.md
# pet_button_conditioner

Upstream input stage for the pet's game-control logic. It synchronizes and debounces three raw push-buttons (test, play, feed) and classifies each press. For every button it produces single-cycle pulses for confirmed press, short press (on release) and long press (on hold threshold), plus a debounced held level. The game-control block consumes these as its `test_press`, `test`, `play_press` and `feed_press` strobes, so it needs no press-lockout timers of its own.

## Interface
- `DEBOUNCE_CYCLES`, 1_000_000: number of stable samples required to confirm a press or release (20 ms at 50 MHz); must be ≥ 2.
- `LONG_PRESS_CYCLES`, 150_000_000: hold time after press confirmation that qualifies as a long press (3 s); must be > `DEBOUNCE_CYCLES`.
- `ACTIVE_LOW`, 1: 1 = raw button reads 0 when pressed; 0 = reads 1 when pressed.
- `clock` input 1: system clock, 50 MHz.
- `Reset` input 1: asynchronous, active-high.
- `btn_raw` input 3: raw pins, asynchronous to `clock`. Bit 0 = test, bit 1 = play, bit 2 = feed.
- `held` output 3: debounced pressed level per button.
- `press_pulse` output 3: one-cycle strobe when a press is confirmed.
- `short_pulse` output 3: one-cycle strobe on confirmed release if the long threshold was not reached.
- `long_pulse` output 3: one-cycle strobe when the hold reaches `LONG_PRESS_CYCLES`.

## Operation
- **Input normalization.** Each bit passes through a 2-flop synchronizer and is normalized to `p = 1` when pressed. Synchronizer flops reset to the released value.
- **Per-channel state.** The three channels are fully independent. Each has its own FSM, a counter of width clog2(`LONG_PRESS_CYCLES`+1), and a `long_flag`.
- **IDLE**
  - `p = 1` → DB_PRESS, cnt ← 0.
- **DB_PRESS**
  - `p = 0` → IDLE (glitch rejected, no output).
  - `p = 1` and cnt == `DEBOUNCE_CYCLES`-1 → PRESSED, cnt ← 0, `long_flag` ← 0, `press_pulse` ← 1, `held` ← 1.
  - Otherwise cnt++.
- **PRESSED**
  - `p = 0` → DB_RELEASE with rcnt ← 0. The hold cnt is retained.
  - cnt == `LONG_PRESS_CYCLES`-1 → LONG, `long_pulse` ← 1, `long_flag` ← 1.
  - Otherwise cnt++.
- **LONG**
  - `p = 0` → DB_RELEASE, rcnt ← 0.
  - The counter stays frozen; no further long pulses are generated however long the button is held.
- **DB_RELEASE**
  - `p = 1` (bounce) → return to LONG if `long_flag`, else PRESSED, resuming the retained hold count.
  - `p = 0` and rcnt == `DEBOUNCE_CYCLES`-1 → IDLE, `held` ← 0, `short_pulse` ← !`long_flag`.
  - Otherwise rcnt++.
  - The release counter can share the channel counter only if the hold count is saved; a separate rcnt of width clog2(`DEBOUNCE_CYCLES`+1) is allowed.
- **Pulse rules.**
  - All pulses are registered and high for exactly one cycle. At most one pulse per channel per cycle.
  - Every confirmed press produces exactly one `press_pulse`, and later exactly one of `short_pulse` or `long_pulse`.
  - A press whose release is still bouncing can still become long: bounces return to PRESSED, and the hold count continues.
- **Arithmetic.** Counters never wrap; LONG freezes the hold count at its threshold.

## Timing
- **Reset values:** all outputs 0, all FSMs IDLE, counters 0, synchronizers released. Reset acts immediately (asynchronous).
- **Press latency.** Edge E = first clock edge sampling the raw pressed level.
  - Synchronized `p` is visible after E+1.
  - DB_PRESS is entered at E+2.
  - `press_pulse` and `held` rise at edge E+2+`DEBOUNCE_CYCLES`, if the pin stays pressed throughout.
- **Long pulse:** asserted at press-confirm edge + `LONG_PRESS_CYCLES`.
- **Release latency.** Edge R = first edge sampling the raw released level. `short_pulse` asserts and `held` falls at R+2+`DEBOUNCE_CYCLES`.
- **Simultaneous events.** Events on different channels in the same cycle are all reported in that cycle.
- **Reset during any state:** the channel is aborted with no pulses. A button still held when `Reset` deasserts is treated as a new press: `press_pulse` appears at E+2+`DEBOUNCE_CYCLES` after the first post-reset sampling edge.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4, `LONG_PRESS_CYCLES`=20, `ACTIVE_LOW`=1.
- **Clean short press.** Drive `btn_raw[1]` low at edge 10 for 12 cycles, then high. Expect `press_pulse[1]` for exactly one cycle at edge 16, `held[1]` high from 16 until `short_pulse[1]` at edge 28 (release sampled at 22), and no `long_pulse`.
- **Glitch rejection.** Drive `btn_raw[2]` low for 3 cycles, then high. Expect all outputs to stay 0.
- **Long press.** Hold `btn_raw[0]` low from edge 10 for 40 cycles. Expect `press_pulse[0]` at edge 16, `long_pulse[0]` at edge 36 and no other long pulse, then on release `held[0]` falls and `short_pulse[0]` stays 0.
- **Release bounce.** After the press is confirmed, toggle the pin released/pressed every 2 cycles for 8 cycles, then hold it pressed. Expect the single press to continue and `long_pulse` still at press-confirm+20, with no extra `press_pulse` or `short_pulse`.
- **Concurrency and reset.**
  - Press all three buttons at the same edge. Expect three `press_pulse` bits in the same cycle.
  - Assert `Reset` mid-hold. Expect all outputs 0 immediately.
  - Deassert `Reset` with the buttons still held. Expect a new `press_pulse` 6 edges after the first post-reset sampling edge.
